rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/zxuno_rom_pkg.sv | 25 ++
 rtl/rom_arb_starve_cnt.sv | 44 ++++
 rtl/rom_arbiter.sv | 126 ++++++++++++
 tb/tb_rom_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxuno_rom_pkg.sv
// Shared definitions for the ZX-Uno boot/system ROM access path.
//
// Contents:
//   ROM_AW, ROM_DW  - geometry of the external 16Kx8 synchronous ROM
//   owner_t         - which port, if any, was granted in the previous cycle
//   starve_cw()     - width of a counter that must reach a given limit

package zxuno_rom_pkg;

  localparam int ROM_AW = 14;
  localparam int ROM_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // Bits needed to hold values 0..limit; never narrower than one bit so a
  // limit of 0 still yields a legal vector.
  function automatic int starve_cw(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating starve counter for the two-port ROM arbiter.
//
// Counts consecutive port-0 grants taken while port 1 was waiting, stops at
// STARVE_LIMIT, and reports when that limit has been reached.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset (count -> 0)
//   inc      - port 0 granted while port 1 is requesting
//   clr      - port 1 granted, or port 1 not requesting this cycle
//   at_limit - count equals STARVE_LIMIT (always true when STARVE_LIMIT = 0)

module rom_arb_starve_cnt
  import zxuno_rom_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = starve_cw(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;

  // Clear wins over increment; the two are never both asserted by the
  // arbiter, but the priority keeps the counter well defined regardless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of an external 16Kx8 synchronous ROM.
//
// Port 0 has fixed priority, but after STARVE_LIMIT consecutive port-0
// grants with port 1 waiting, port 1 is given one forced slot. One grant per
// cycle, data returns one cycle later, so sustained throughput is one byte
// per cycle.
//
// Handshake (both ports): a port raises pN_req with pN_addr stable and keeps
// both unchanged until it sees pN_gnt high in the same cycle; that cycle
// consumes the request. pN_valid rises exactly one cycle after each grant,
// for one cycle, with pN_data carrying the ROM byte.
//
// Ports:
//   clk, rst_n         - clock (rising edge), synchronous active-low reset
//   p0_req, p0_addr    - port 0 read request and byte address
//   p1_req, p1_addr    - port 1 read request and byte address
//   p0_gnt, p1_gnt     - combinational same-cycle grants (one-hot or zero)
//   p0_valid, p1_valid - read data strobes, one cycle after the grant
//   p0_data, p1_data   - read data, both fed from rom_dout
//   rom_a              - address to the external ROM
//   rom_dout           - data from the external ROM (1-cycle latency)

module rom_arbiter
  import zxuno_rom_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [ROM_AW-1:0] p0_addr,
  input  logic              p1_req,
  input  logic [ROM_AW-1:0] p1_addr,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_valid,
  output logic              p1_valid,
  output logic [ROM_DW-1:0] p0_data,
  output logic [ROM_DW-1:0] p1_data,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [ROM_DW-1:0] rom_dout
);

  owner_t            owner_q;
  owner_t            owner_d;
  logic [ROM_AW-1:0] last_q;
  logic              at_limit;
  logic              force_p1;
  logic              starve_inc;
  logic              starve_clr;

  // Port 1 has waited long enough: it takes this slot even if port 0 asks.
  assign force_p1 = at_limit && p1_req;

  // Grant decision. Gated by rst_n so no request is accepted while reset is
  // being applied, whatever the registers still hold.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      if (p0_req && !force_p1) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (p0_gnt) begin
      owner_d = OWN_P0;
    end else if (p1_gnt) begin
      owner_d = OWN_P1;
    end
  end

  // Address mux: the granted port drives the ROM directly in its grant
  // cycle; otherwise the last granted address is replayed so rom_dout does
  // not toggle while idle.
  always_comb begin
    rom_a = last_q;
    if (!rst_n) begin
      rom_a = '0;
    end else if (p0_gnt) begin
      rom_a = p0_addr;
    end else if (p1_gnt) begin
      rom_a = p1_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (p0_gnt || p1_gnt) begin
        last_q <= rom_a;
      end
    end
  end

  // A grant taken just before reset asserts must not surface as a valid in
  // the reset cycle, so the strobes are qualified with rst_n.
  assign p0_valid = rst_n && (owner_q == OWN_P0);
  assign p1_valid = rst_n && (owner_q == OWN_P1);
  assign p0_data  = rom_dout;
  assign p1_data  = rom_dout;

  // The forced slot is a port-1 grant, so it clears the counter and port 0
  // is back in front on the following cycle.
  assign starve_inc = p0_gnt && p1_req;
  assign starve_clr = p1_gnt || !p1_req;

  rom_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with STARVE_LIMIT = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. A behavioural ROM and a reference model live in the bench.

module tb_rom_arbiter;

  localparam int LIMIT = 4;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0;
  logic [13:0] p0_addr = '0;
  logic        p1_req = 1'b0;
  logic [13:0] p1_addr = '0;
  logic        p0_gnt, p1_gnt, p0_valid, p1_valid;
  logic [7:0]  p0_data, p1_data;
  logic [13:0] rom_a;
  logic [7:0]  rom_dout;

  always #5 clk = ~clk;

  rom_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0_req  (p0_req),
    .p0_addr (p0_addr),
    .p1_req  (p1_req),
    .p1_addr (p1_addr),
    .p0_gnt  (p0_gnt),
    .p1_gnt  (p1_gnt),
    .p0_valid(p0_valid),
    .p1_valid(p1_valid),
    .p0_data (p0_data),
    .p1_data (p1_data),
    .rom_a   (rom_a),
    .rom_dout(rom_dout)
  );

  // Behavioural 16Kx8 synchronous ROM.
  logic [7:0] rom_mem [0:16383];
  always @(posedge clk) rom_dout <= rom_mem[rom_a];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------- reference model
  // m_starve: consecutive port-0 wins while port 1 waited (capped at LIMIT)
  // m_owner : grantee of the previous cycle (0 none, 1 port 0, 2 port 1)
  // exp_q   : scoreboard of ROM bytes owed to the previous cycle's grantee
  int          m_starve = 0;
  int          m_owner  = 0;
  logic [13:0] m_last   = '0;
  logic [7:0]  exp_q[$];

  function automatic int model_grant();
    if (!rst_n) return 0;
    if (p1_req && m_starve >= LIMIT) return 2;
    if (p0_req) return 1;
    if (p1_req) return 2;
    return 0;
  endfunction

  function automatic logic [13:0] model_rom_a();
    int g = model_grant();
    if (!rst_n) return 14'h0;
    if (g == 1) return p0_addr;
    if (g == 2) return p1_addr;
    return m_last;
  endfunction

  function automatic logic [1:0] gnt_bits(input int g);
    return {g == 2, g == 1};
  endfunction

  function automatic logic [1:0] exp_valid();
    return {rst_n && m_owner == 2, rst_n && m_owner == 1};
  endfunction

  // Apply the rules for the cycle whose inputs are currently on the pins.
  task automatic model_advance();
    int g;
    if (!rst_n) begin
      m_starve = 0;
      m_owner  = 0;
      m_last   = '0;
      exp_q.delete();
      return;
    end
    if (m_owner != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    g = model_grant();
    if (g == 1) begin
      exp_q.push_back(rom_mem[p0_addr]);
      m_last = p0_addr;
      m_starve = p1_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    end else if (g == 2) begin
      exp_q.push_back(rom_mem[p1_addr]);
      m_last = p1_addr;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    m_owner = g;
  endtask

  // ------------------------------------------------------------------- driver
  // Close out the current cycle in the model, then present new inputs and
  // move to the sampling point of the new cycle.
  task automatic drive(input logic r, input logic r0, input logic [13:0] a0,
                       input logic r1, input logic [13:0] a1);
    model_advance();
    @(posedge clk);
    #1;
    rst_n = r; p0_req = r0; p0_addr = a0; p1_req = r1; p1_addr = a1;
    #4;
  endtask

  // -------------------------------------------------------------------- tests
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 14'($urandom), 1'b1, 14'($urandom));
      n_tests++;
      if ({p1_gnt, p0_gnt} !== 2'b00) begin
        n_fail++; $display("FAIL reset_gnt: got %b want 00", {p1_gnt, p0_gnt});
      end
      n_tests++;
      if ({p1_valid, p0_valid} !== 2'b00 || rom_a !== 14'h0) begin
        n_fail++; $display("FAIL reset_outs: valid=%b rom_a=%h want 00/0000", {p1_valid, p0_valid}, rom_a);
      end
    end
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    n_tests++;
    if ({p1_valid, p0_valid, p1_gnt, p0_gnt} !== 4'b0000 || rom_a !== 14'h0) begin
      n_fail++; $display("FAIL reset_release: v/g=%b rom_a=%h want 0000/0000",
                         {p1_valid, p0_valid, p1_gnt, p0_gnt}, rom_a);
    end
  endtask

  task automatic test_p0_single();
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    drive(1'b1, 1'b1, 14'h0000, 1'b0, 14'h0);
    n_tests++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || rom_a !== 14'h0000) begin
      n_fail++; $display("FAIL p0_single_gnt: p0_gnt=%b p1_gnt=%b rom_a=%h want 1/0/0000", p0_gnt, p1_gnt, rom_a);
    end
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    n_tests++;
    if (p0_valid !== 1'b1 || p0_data !== 8'h3E) begin
      n_fail++; $display("FAIL p0_single_data: valid=%b data=%h want 1/3e", p0_valid, p0_data);
    end
    n_tests++;
    if (p1_valid !== 1'b0 || p1_gnt !== 1'b0 || p0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL p0_single_idle: p1_valid=%b p1_gnt=%b p0_gnt=%b want 0/0/0", p1_valid, p1_gnt, p0_gnt);
    end
  endtask

  task automatic test_starve_pattern();
    logic [13:0] a0 = 14'($urandom), a1 = 14'($urandom), prev_addr = '0;
    int want, prev = 0;
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    for (int i = 0; i < 15; i++) begin
      want = (i % 5 == 4) ? 2 : 1;
      drive(1'b1, 1'b1, a0, 1'b1, a1);
      n_tests++;
      if ({p1_gnt, p0_gnt} !== gnt_bits(want) || rom_a !== (want == 1 ? a0 : a1)) begin
        n_fail++; $display("FAIL starve_pattern cycle %0d: gnt=%b rom_a=%h want %b/%h",
                           i, {p1_gnt, p0_gnt}, rom_a, gnt_bits(want), (want == 1 ? a0 : a1));
      end
      n_tests++;
      if ({p1_valid, p0_valid} !== gnt_bits(prev) ||
          (prev != 0 && rom_dout !== rom_mem[prev_addr])) begin
        n_fail++; $display("FAIL starve_valid cycle %0d: valid=%b data=%h want %b/%h",
                           i, {p1_valid, p0_valid}, rom_dout, gnt_bits(prev), rom_mem[prev_addr]);
      end
      prev = want;
      prev_addr = (want == 1) ? a0 : a1;
      if (want == 1) a0 = 14'($urandom); else a1 = 14'($urandom);
    end
  endtask

  task automatic test_p1_wrap();
    logic [13:0] seq [3];
    seq[0] = 14'h3FFE; seq[1] = 14'h3FFF; seq[2] = 14'h0000;
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    for (int j = 0; j < 4; j++) begin
      if (j < 3) drive(1'b1, 1'b0, 14'h0, 1'b1, seq[j]);
      else       drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
      if (j < 3) begin
        n_tests++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || rom_a !== seq[j]) begin
          n_fail++; $display("FAIL p1_wrap_gnt %0d: p1_gnt=%b p0_gnt=%b rom_a=%h want 1/0/%h", j, p1_gnt, p0_gnt, rom_a, seq[j]);
        end
      end
      if (j > 0) begin
        n_tests++;
        if (p1_valid !== 1'b1 || p0_valid !== 1'b0 || p1_data !== rom_mem[seq[j-1]]) begin
          n_fail++; $display("FAIL p1_wrap_data %0d: p1_valid=%b p0_valid=%b data=%h want 1/0/%h",
                             j, p1_valid, p0_valid, p1_data, rom_mem[seq[j-1]]);
        end
      end
    end
  endtask

  task automatic test_reset_after_grant();
    logic [13:0] a = 14'($urandom_range(1, 16383));
    logic [13:0] b = 14'($urandom);
    drive(1'b1, 1'b1, a, 1'b0, 14'h0);
    n_tests++;
    if (p0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_after_grant_T: p0_gnt=%b want 1", p0_gnt);
    end
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b1, a, 1'b1, 14'($urandom));
      n_tests++;
      if (p0_valid !== 1'b0 || {p1_gnt, p0_gnt} !== 2'b00 || rom_a !== 14'h0) begin
        n_fail++; $display("FAIL rst_after_grant_T+%0d: p0_valid=%b gnt=%b rom_a=%h want 0/00/0000",
                           k, p0_valid, {p1_gnt, p0_gnt}, rom_a);
      end
    end
    drive(1'b1, 1'b1, b, 1'b0, 14'h0);
    n_tests++;
    if (p0_gnt !== 1'b1 || p0_valid !== 1'b0 || rom_a !== b) begin
      n_fail++; $display("FAIL first_after_reset: p0_gnt=%b p0_valid=%b rom_a=%h want 1/0/%h", p0_gnt, p0_valid, rom_a, b);
    end
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    n_tests++;
    if (p0_valid !== 1'b1 || p0_data !== rom_mem[b]) begin
      n_fail++; $display("FAIL first_after_reset_data: valid=%b data=%h want 1/%h", p0_valid, p0_data, rom_mem[b]);
    end
  endtask

  task automatic test_idle_hold();
    drive(1'b1, 1'b1, 14'h1234, 1'b0, 14'h0);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 14'($urandom), 1'b0, 14'($urandom));
      n_tests++;
      if (rom_a !== 14'h1234 || rom_dout !== rom_mem[14'h1234]) begin
        n_fail++; $display("FAIL idle_hold %0d: rom_a=%h rom_dout=%h want 1234/%h", k, rom_a, rom_dout, rom_mem[14'h1234]);
      end
      n_tests++;
      if ({p1_valid, p0_valid} !== (k == 1 ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL idle_valid %0d: valid=%b want %b", k, {p1_valid, p0_valid}, (k == 1 ? 2'b01 : 2'b00));
      end
    end
  endtask

  task automatic test_starve_restart();
    logic [8:0] p1r  = 9'b1_1111_0111;  // bit i = p1_req in cycle i
    logic [8:0] p1wn = 9'b1_0000_0000;  // bit i = port 1 expected to win
    int want;
    drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0);
    for (int i = 0; i < 9; i++) begin
      want = p1wn[i] ? 2 : 1;
      drive(1'b1, 1'b1, 14'($urandom), p1r[i], 14'($urandom));
      n_tests++;
      if ({p1_gnt, p0_gnt} !== gnt_bits(want)) begin
        n_fail++; $display("FAIL starve_restart cycle %0d: gnt=%b want %b", i, {p1_gnt, p0_gnt}, gnt_bits(want));
      end
    end
  endtask

  task automatic test_random();
    logic r, r0 = 1'b0, r1 = 1'b0, hold0 = 1'b0, hold1 = 1'b0;
    logic [13:0] a0 = '0, a1 = '0;
    int g;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) != 0);
      if (!hold0) begin r0 = ($urandom_range(0, 2) != 0); a0 = 14'($urandom); end
      if (!hold1) begin r1 = ($urandom_range(0, 2) != 0); a1 = 14'($urandom); end
      drive(r, r0, a0, r1, a1);
      g = model_grant();
      n_tests++;
      if ({p1_gnt, p0_gnt} !== gnt_bits(g) || rom_a !== model_rom_a()) begin
        n_fail++; $display("FAIL random_gnt %0d: gnt=%b rom_a=%h want %b/%h",
                           i, {p1_gnt, p0_gnt}, rom_a, gnt_bits(g), model_rom_a());
      end
      n_tests++;
      if ({p1_valid, p0_valid} !== exp_valid()) begin
        n_fail++; $display("FAIL random_valid %0d: valid=%b want %b", i, {p1_valid, p0_valid}, exp_valid());
      end
      if (rst_n && m_owner != 0 && exp_q.size() > 0) begin
        n_tests++;
        if ((m_owner == 1 ? p0_data : p1_data) !== exp_q[0]) begin
          n_fail++; $display("FAIL random_data %0d: data=%h want %h", i, (m_owner == 1 ? p0_data : p1_data), exp_q[0]);
        end
      end
      hold0 = r && r0 && (g != 1);
      hold1 = r && r1 && (g != 2);
    end
  endtask

  // --------------------------------------------------------------- sequencing
  initial begin
    for (int i = 0; i < 16384; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'h3E;
    test_reset();
    test_p0_single();
    test_starve_pattern();
    test_p1_wrap();
    test_reset_after_grant();
    test_idle_hold();
    test_starve_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
